// File: rtl/alu_pkg.sv
// Shared widths, RV32I opcode/funct3 encodings and result type for the
// integer execution unit.
package alu_pkg;

    localparam int DATA_WID   = 32;
    localparam int ADDR_WID   = 32;
    localparam int ROB_ID_WID = 4;
    localparam int OPCODE_WID = 7;
    localparam int FUNC3_WID  = 3;

    localparam logic [OPCODE_WID-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_WID-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WID-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_WID-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_WID-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WID-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPCODE_WID-1:0] OPC_OP     = 7'b0110011;

    localparam logic [FUNC3_WID-1:0] F3_ADD  = 3'b000;
    localparam logic [FUNC3_WID-1:0] F3_SLL  = 3'b001;
    localparam logic [FUNC3_WID-1:0] F3_SLT  = 3'b010;
    localparam logic [FUNC3_WID-1:0] F3_SLTU = 3'b011;
    localparam logic [FUNC3_WID-1:0] F3_XOR  = 3'b100;
    localparam logic [FUNC3_WID-1:0] F3_SR   = 3'b101;
    localparam logic [FUNC3_WID-1:0] F3_OR   = 3'b110;
    localparam logic [FUNC3_WID-1:0] F3_AND  = 3'b111;

    localparam logic [FUNC3_WID-1:0] F3_BEQ  = 3'b000;
    localparam logic [FUNC3_WID-1:0] F3_BNE  = 3'b001;
    localparam logic [FUNC3_WID-1:0] F3_BLT  = 3'b100;
    localparam logic [FUNC3_WID-1:0] F3_BGE  = 3'b101;
    localparam logic [FUNC3_WID-1:0] F3_BLTU = 3'b110;
    localparam logic [FUNC3_WID-1:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [DATA_WID-1:0] data;
        logic                jump;
        logic [ADDR_WID-1:0] target;
    } alu_res_t;

    // funct3 codes 010/011 are not valid branches and resolve as not taken.
    function automatic logic branch_taken(
        input logic [FUNC3_WID-1:0] f3,
        input logic [DATA_WID-1:0]  a,
        input logic [DATA_WID-1:0]  b
    );
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return $signed(a) <  $signed(b);
            F3_BGE:  return $signed(a) >= $signed(b);
            F3_BLTU: return a <  b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_if.sv
// Issue bundle from the reservation station and the registered result
// broadcast seen by RS, LSB and ROB.
interface alu_if;
    import alu_pkg::*;

    logic                  exe_valid;
    logic [OPCODE_WID-1:0] exe_opcode;
    logic [FUNC3_WID-1:0]  exe_func3;
    logic                  exe_func1;
    logic [DATA_WID-1:0]   exe_data1;
    logic [DATA_WID-1:0]   exe_data2;
    logic [DATA_WID-1:0]   exe_imm;
    logic [ADDR_WID-1:0]   exe_off;
    logic [ADDR_WID-1:0]   exe_pc;
    logic [ROB_ID_WID-1:0] exe_rob_target;

    logic                  alu_valid;
    logic [ROB_ID_WID-1:0] alu_rob_id;
    logic [DATA_WID-1:0]   alu_data;
    logic                  alu_jump;
    logic [ADDR_WID-1:0]   alu_target_pc;

    modport master (
        output exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
               exe_imm, exe_off, exe_pc, exe_rob_target,
        input  alu_valid, alu_rob_id, alu_data, alu_jump, alu_target_pc
    );

    modport slave (
        input  exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
               exe_imm, exe_off, exe_pc, exe_rob_target,
        output alu_valid, alu_rob_id, alu_data, alu_jump, alu_target_pc
    );

endinterface

// File: rtl/alu_core.sv
// Combinational datapath: operand select, arithmetic/logic, branch compare
// and next-PC resolution for one issued instruction.
module alu_core
    import alu_pkg::*;
(
    input  logic [OPCODE_WID-1:0] i_opcode,
    input  logic [FUNC3_WID-1:0]  i_func3,
    input  logic                  i_func1,
    input  logic [DATA_WID-1:0]   i_data1,
    input  logic [DATA_WID-1:0]   i_data2,
    input  logic [DATA_WID-1:0]   i_imm,
    input  logic [ADDR_WID-1:0]   i_off,
    input  logic [ADDR_WID-1:0]   i_pc,
    output alu_res_t              o_res
);

    logic [DATA_WID-1:0] w_b;
    logic [4:0]          w_shamt;
    logic                w_sub;
    logic [DATA_WID-1:0] w_alu;
    logic [ADDR_WID-1:0] w_pc4;
    logic [ADDR_WID-1:0] w_pc_off;
    logic [ADDR_WID-1:0] w_jalr;
    logic                w_taken;

    assign w_b      = (i_opcode == OPC_OP) ? i_data2 : i_imm;
    assign w_shamt  = w_b[4:0];
    // Only register-register ADD can become SUB; bit 30 of ADDI is immediate data.
    assign w_sub    = (i_opcode == OPC_OP) && i_func1;
    assign w_pc4    = i_pc + 32'd4;
    assign w_pc_off = i_pc + i_off;
    assign w_jalr   = (i_data1 + i_imm) & ~32'd1;
    assign w_taken  = branch_taken(i_func3, i_data1, i_data2);

    always_comb begin
        w_alu = '0;
        case (i_func3)
            F3_ADD:  w_alu = w_sub ? (i_data1 - w_b) : (i_data1 + w_b);
            F3_SLL:  w_alu = i_data1 << w_shamt;
            F3_SLT:  w_alu = {31'd0, $signed(i_data1) < $signed(w_b)};
            F3_SLTU: w_alu = {31'd0, i_data1 < w_b};
            F3_XOR:  w_alu = i_data1 ^ w_b;
            F3_SR:   w_alu = i_func1 ? DATA_WID'($signed(i_data1) >>> w_shamt)
                                     : (i_data1 >> w_shamt);
            F3_OR:   w_alu = i_data1 | w_b;
            F3_AND:  w_alu = i_data1 & w_b;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        o_res.data   = '0;
        o_res.jump   = 1'b0;
        o_res.target = w_pc4;
        case (i_opcode)
            OPC_LUI:   o_res.data = i_imm;
            OPC_AUIPC: o_res.data = i_pc + i_imm;
            OPC_JAL: begin
                o_res.data   = w_pc4;
                o_res.jump   = 1'b1;
                o_res.target = w_pc_off;
            end
            OPC_JALR: begin
                o_res.data   = w_pc4;
                o_res.jump   = 1'b1;
                o_res.target = w_jalr;
            end
            OPC_BRANCH: begin
                o_res.jump   = w_taken;
                o_res.target = w_taken ? w_pc_off : w_pc4;
            end
            OPC_OPIMM, OPC_OP: o_res.data = w_alu;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered wrapper: one-cycle result broadcast with reset, rollback flush
// and global-enable freeze around the combinational core.
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_rdy,
    input  logic i_rollback,
    alu_if.slave bus
);

    alu_res_t              w_res;
    logic                  r_valid;
    logic [ROB_ID_WID-1:0] r_rob_id;
    logic [DATA_WID-1:0]   r_data;
    logic                  r_jump;
    logic [ADDR_WID-1:0]   r_target;

    alu_core u_core (
        .i_opcode (bus.exe_opcode),
        .i_func3  (bus.exe_func3),
        .i_func1  (bus.exe_func1),
        .i_data1  (bus.exe_data1),
        .i_data2  (bus.exe_data2),
        .i_imm    (bus.exe_imm),
        .i_off    (bus.exe_off),
        .i_pc     (bus.exe_pc),
        .o_res    (w_res)
    );

    // With rdy low consumers are frozen too, so a held alu_valid is not a
    // second completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_rob_id <= '0;
            r_data   <= '0;
            r_jump   <= 1'b0;
            r_target <= '0;
        end else if (i_rdy) begin
            if (i_rollback) begin
                r_valid <= 1'b0;
            end else if (bus.exe_valid) begin
                r_valid  <= 1'b1;
                r_rob_id <= bus.exe_rob_target;
                r_data   <= w_res.data;
                r_jump   <= w_res.jump;
                r_target <= w_res.target;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.alu_valid     = r_valid;
    assign bus.alu_rob_id    = r_rob_id;
    assign bus.alu_data      = r_data;
    assign bus.alu_jump      = r_jump;
    assign bus.alu_target_pc = r_target;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed vector table, randomized issues against a
// behavioural model, then pipeline/flush/freeze/async-reset sequences.
module tb_alu;

    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_OPIMM  = 7'b0010011;
    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f1;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] off;
        logic [31:0] pc;
        logic [3:0]  rob;
        logic [31:0] exp_data;
        logic        exp_jump;
        logic [31:0] exp_tgt;
    } vec_t;

    logic clk;
    logic rst;
    logic rdy;
    logic rollback;
    int   n_chk;
    int   n_err;

    alu_if bus ();

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .i_rdy      (rdy),
        .i_rollback (rollback),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] id,
                           input logic [31:0] d, input logic j, input logic [31:0] t);
        chk({tag, ".valid"}, 64'(bus.alu_valid), 64'(v));
        chk({tag, ".id"},    64'(bus.alu_rob_id), 64'(id));
        chk({tag, ".data"},  64'(bus.alu_data), 64'(d));
        chk({tag, ".jump"},  64'(bus.alu_jump), 64'(j));
        chk({tag, ".target"}, 64'(bus.alu_target_pc), 64'(t));
    endtask

    task automatic drive(input vec_t v, input logic valid);
        bus.exe_valid      = valid;
        bus.exe_opcode     = v.opc;
        bus.exe_func3      = v.f3;
        bus.exe_func1      = v.f1;
        bus.exe_data1      = v.d1;
        bus.exe_data2      = v.d2;
        bus.exe_imm        = v.imm;
        bus.exe_off        = v.off;
        bus.exe_pc         = v.pc;
        bus.exe_rob_target = v.rob;
    endtask

    // Issue on the next edge and return just after it.
    task automatic issue(input vec_t v);
        @(negedge clk);
        drive(v, 1'b1);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                input logic [31:0] off, input logic [31:0] pc, input logic [3:0] rob,
                                input logic [31:0] ed, input logic ej, input logic [31:0] et);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f1 = f1; v.d1 = d1; v.d2 = d2; v.imm = imm;
        v.off = off; v.pc = pc; v.rob = rob;
        v.exp_data = ed; v.exp_jump = ej; v.exp_tgt = et;
        return v;
    endfunction

    // Reference model: straight from the instruction semantics using integer arithmetic.
    function automatic void ref_model(input vec_t v, output logic [31:0] data,
                                      output logic jump, output logic [31:0] tgt);
        logic [31:0] b;
        int          sa, sb, ra, rb;
        int unsigned sh;
        longint      wide;
        logic        taken;
        data = 32'd0;
        jump = 1'b0;
        tgt  = v.pc + 32'd4;
        b    = (v.opc == T_OP) ? v.d2 : v.imm;
        sa   = v.d1;
        sb   = b;
        sh   = b % 32;
        if (v.opc == T_OP || v.opc == T_OPIMM) begin
            case (v.f3)
                3'd0: data = (v.opc == T_OP && v.f1) ? v.d1 - b : v.d1 + b;
                3'd1: data = v.d1 * (32'd1 << sh);
                3'd2: data = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: data = (v.d1 < b) ? 32'd1 : 32'd0;
                3'd4: data = v.d1 ^ b;
                3'd5: begin
                    wide = sa;
                    data = v.f1 ? 32'(wide >>> sh) : v.d1 / (32'd1 << sh);
                end
                3'd6: data = v.d1 | b;
                default: data = v.d1 & b;
            endcase
        end else if (v.opc == T_LUI) begin
            data = v.imm;
        end else if (v.opc == T_AUIPC) begin
            data = v.pc + v.imm;
        end else if (v.opc == T_JAL) begin
            data = v.pc + 32'd4;
            jump = 1'b1;
            tgt  = v.pc + v.off;
        end else if (v.opc == T_JALR) begin
            data = v.pc + 32'd4;
            jump = 1'b1;
            tgt  = (v.d1 + v.imm) & 32'hFFFF_FFFE;
        end else if (v.opc == T_BRANCH) begin
            ra = v.d1;
            rb = v.d2;
            case (v.f3)
                3'd0: taken = v.d1 == v.d2;
                3'd1: taken = v.d1 != v.d2;
                3'd4: taken = ra < rb;
                3'd5: taken = ra >= rb;
                3'd6: taken = v.d1 < v.d2;
                3'd7: taken = v.d1 >= v.d2;
                default: taken = 1'b0;
            endcase
            jump = taken;
            tgt  = taken ? v.pc + v.off : v.pc + 32'd4;
        end
    endfunction

    vec_t vecs[14];
    logic [6:0] opcs[8];

    initial begin
        vec_t        v;
        logic [31:0] md, mt;
        logic        mj;
        n_chk = 0;
        n_err = 0;

        vecs[0]  = mk(T_OP,     3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 32'h1000, 4'd3, 32'hFFFF_FFFE, 1'b0, 32'h1004);
        vecs[1]  = mk(T_OPIMM,  3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'h404, 32'd0, 32'h2000, 4'd4, 32'hF800_0000, 1'b0, 32'h2004);
        vecs[2]  = mk(T_OP,     3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h10, 4'd5, 32'd1, 1'b0, 32'h14);
        vecs[3]  = mk(T_OP,     3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h20, 4'd6, 32'd0, 1'b0, 32'h24);
        vecs[4]  = mk(T_BRANCH, 3'd6, 1'b0, 32'd1, 32'd2, 32'd0, 32'h20, 32'h100, 4'd7, 32'd0, 1'b1, 32'h120);
        vecs[5]  = mk(T_BRANCH, 3'd6, 1'b0, 32'd2, 32'd1, 32'd0, 32'h20, 32'h100, 4'd8, 32'd0, 1'b0, 32'h104);
        vecs[6]  = mk(T_JALR,   3'd0, 1'b0, 32'h1001, 32'd0, 32'd2, 32'd0, 32'h40, 4'd9, 32'h44, 1'b1, 32'h1002);
        vecs[7]  = mk(T_OPIMM,  3'd0, 1'b1, 32'd10, 32'd99, 32'd3, 32'd0, 32'h50, 4'd10, 32'd13, 1'b0, 32'h54);
        vecs[8]  = mk(T_LUI,    3'd0, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 32'h60, 4'd11, 32'h1234_5000, 1'b0, 32'h64);
        vecs[9]  = mk(T_AUIPC,  3'd0, 1'b0, 32'd0, 32'd0, 32'h1000, 32'd0, 32'h400, 4'd12, 32'h1400, 1'b0, 32'h404);
        vecs[10] = mk(T_JAL,    3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h80, 4'd13, 32'h84, 1'b1, 32'h78);
        vecs[11] = mk(T_LOAD,   3'd2, 1'b0, 32'd7, 32'd8, 32'd9, 32'h10, 32'h90, 4'd14, 32'd0, 1'b0, 32'h94);
        vecs[12] = mk(T_BRANCH, 3'd2, 1'b0, 32'd4, 32'd4, 32'd0, 32'h40, 32'hA0, 4'd15, 32'd0, 1'b0, 32'hA4);
        vecs[13] = mk(T_OP,     3'd1, 1'b0, 32'd3, 32'h21, 32'd0, 32'd0, 32'hB0, 4'd2, 32'd6, 1'b0, 32'hB4);

        opcs = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH, T_OPIMM, T_OP, T_LOAD};

        rst      = 1'b1;
        rdy      = 1'b1;
        rollback = 1'b0;
        drive(vecs[0], 1'b0);
        #2;
        chk_out("reset", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i]);
            chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].rob,
                    vecs[i].exp_data, vecs[i].exp_jump, vecs[i].exp_tgt);
        end

        for (int i = 0; i < 200; i++) begin
            v.opc = opcs[$urandom_range(0, 7)];
            v.f3  = 3'($urandom_range(0, 7));
            v.f1  = 1'($urandom_range(0, 1));
            v.d1  = $urandom;
            v.d2  = ($urandom_range(0, 3) == 0) ? v.d1 : $urandom;
            v.imm = $urandom;
            v.off = $urandom;
            v.pc  = $urandom;
            v.rob = 4'($urandom_range(0, 15));
            ref_model(v, md, mj, mt);
            issue(v);
            chk_out($sformatf("rand%0d", i), 1'b1, v.rob, md, mj, mt);
        end

        // Back-to-back issues with distinct ids, then an idle edge.
        for (int i = 1; i <= 3; i++) begin
            v = mk(T_OPIMM, 3'd0, 1'b0, 32'd100, 32'd0, 32'(i), 32'd0, 32'h300, 4'(i), 32'd0, 1'b0, 32'd0);
            issue(v);
            chk_out($sformatf("pipe%0d", i), 1'b1, 4'(i), 32'd100 + 32'(i), 1'b0, 32'h304);
        end
        @(negedge clk);
        bus.exe_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_out("idle", 1'b0, 4'd3, 32'd103, 1'b0, 32'h304);

        // Rollback dominates a simultaneous issue.
        @(negedge clk);
        rollback = 1'b1;
        drive(mk(T_LUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'hDEAD_0000, 32'd0, 32'h500, 4'd5, 32'd0, 1'b0, 32'd0), 1'b1);
        @(posedge clk);
        #1;
        chk_out("rollback", 1'b0, 4'd3, 32'd103, 1'b0, 32'h304);
        @(negedge clk);
        rollback = 1'b0;

        // Freeze: rdy low for two edges holds everything, including valid.
        issue(mk(T_LUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'hAAAA_0000, 32'd0, 32'h600, 4'd6, 32'd0, 1'b0, 32'd0));
        chk_out("pre_freeze", 1'b1, 4'd6, 32'hAAAA_0000, 1'b0, 32'h604);
        @(negedge clk);
        rdy = 1'b0;
        drive(mk(T_JAL, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h100, 32'h700, 4'd7, 32'd0, 1'b0, 32'd0), 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("freeze%0d", i), 1'b1, 4'd6, 32'hAAAA_0000, 1'b0, 32'h604);
        end
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        chk_out("unfreeze", 1'b1, 4'd7, 32'h704, 1'b1, 32'h800);

        // Async reset between edges while a broadcast is live.
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        bus.exe_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("post_rst", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
